logic_gate_unit: RTL and testbench

Parametrised, clocked successor to the two-input combinational gate demo used on the TinyFPGA board. It takes N_IN raw switch/pin inputs and, for each one, synchronises it and then debounces it. It then applies a run-time selectable logic function across all debounced inputs and drives a registered output. A change strobe and a saturating toggle counter accompany the output, for LED and UART-status use on the board.

---
 rtl/logic_gate_unit_pkg.sv | 23 ++
 rtl/logic_gate_unit_debouncer.sv | 52 +++++
 rtl/logic_gate_unit.sv | 88 ++++++++
 tb/tb_logic_gate_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_unit_pkg.sv
// Shared definitions for logic_gate_unit: function-select encodings,
// default debounce lengths and the debounce counter width helper.
package logic_gate_unit_pkg;

  typedef enum logic [2:0] {
    MODE_AND  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_XOR  = 3'd2,
    MODE_NAND = 3'd3,
    MODE_NOR  = 3'd4,
    MODE_XNOR = 3'd5,
    MODE_PASS = 3'd6,
    MODE_NOT  = 3'd7
  } mode_e;

  localparam int unsigned DEBOUNCE_SIM   = 4;
  localparam int unsigned DEBOUNCE_BOARD = 50000;

  function automatic int unsigned deb_cnt_width(input int unsigned cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/logic_gate_unit_debouncer.sv
// Single-channel input conditioner: 2-flop synchroniser followed by a
// stability counter that only lets a level through after DEBOUNCE_CYCLES.
module input_debouncer
  import logic_gate_unit_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_SIM
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic clean_o
);

  localparam int unsigned CW = deb_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q;
  logic          sync_q;
  logic          clean_q, clean_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= raw_i;
      sync_q  <= meta_q;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any cycle where the synchronised level agrees with the clean one
  // restarts the count, so short glitches never accumulate.
  always_comb begin
    clean_d = clean_q;
    cnt_d   = '0;
    if (sync_q != clean_q) begin
      if (cnt_q == LAST) begin
        clean_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign clean_o = clean_q;

endmodule

// File: rtl/logic_gate_unit.sv
// Debounced N-input selectable logic gate with registered output, change
// strobe and saturating toggle counter (counter built only with TOGGLE_COUNT_EN).
module logic_gate_unit
  import logic_gate_unit_pkg::*;
#(
  parameter int unsigned N_IN            = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_SIM,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IN-1:0]  in_raw,
  input  logic [2:0]       mode,
  output logic             out_0,
  output logic             out_changed,
  output logic [N_IN-1:0]  in_clean,
  output logic [CNT_W-1:0] toggle_cnt
);

  logic  out_q, out_d;
  logic  chg_q;
  mode_e mode_sel;

  for (genvar g = 0; g < N_IN; g++) begin : g_deb
    input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (in_raw[g]),
      .clean_o (in_clean[g])
    );
  end

  assign mode_sel = mode_e'(mode);

  always_comb begin
    out_d = 1'b0;
    case (mode_sel)
      MODE_AND:  out_d = &in_clean;
      MODE_OR:   out_d = |in_clean;
      MODE_XOR:  out_d = ^in_clean;
      MODE_NAND: out_d = ~&in_clean;
      MODE_NOR:  out_d = ~|in_clean;
      MODE_XNOR: out_d = ~^in_clean;
      MODE_PASS: out_d = in_clean[0];
      MODE_NOT:  out_d = ~in_clean[0];
      default:   out_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= 1'b0;
      chg_q <= 1'b0;
    end else begin
      out_q <= out_d;
      chg_q <= (out_d != out_q);
    end
  end

  assign out_0       = out_q;
  assign out_changed = chg_q;

`ifdef TOGGLE_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((out_d != out_q) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign toggle_cnt = cnt_q;
`else
  assign toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Self-checking bench for logic_gate_unit: behavioural window-based model
// for the default instance, directed checks for a 4-input/8-cycle/2-bit instance.
module tb_logic_gate_unit;

  localparam int unsigned N = 2;
  localparam int unsigned D = 4;
  localparam int unsigned CMAX = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst2;
  logic [1:0] raw;
  logic [2:0] mode;
  logic       out0, chg;
  logic [1:0] clean;
  logic [7:0] tcnt;
  logic [3:0] raw2;
  logic [2:0] mode2;
  logic       out2, chg2;
  logic [3:0] clean2;
  logic [1:0] tcnt2;

  logic_gate_unit u_dut (
    .clk(clk), .rst(rst), .in_raw(raw), .mode(mode),
    .out_0(out0), .out_changed(chg), .in_clean(clean), .toggle_cnt(tcnt)
  );

  logic_gate_unit #(.N_IN(4), .DEBOUNCE_CYCLES(8), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst2), .in_raw(raw2), .mode(mode2),
    .out_0(out2), .out_changed(chg2), .in_clean(clean2), .toggle_cnt(tcnt2)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state (default instance)
  logic [1:0] m_clean;
  logic       m_out, m_chg;
  int         m_cnt;
  logic [1:0] raw_hist[$];
  logic [1:0] s_hist[$];

  function automatic logic gate_ref(input logic [2:0] m, input logic [1:0] v);
    int ones;
    ones = $countones(v);
    case (m)
      3'd0: return ones == N;
      3'd1: return ones > 0;
      3'd2: return (ones % 2) == 1;
      3'd3: return ones != N;
      3'd4: return ones == 0;
      3'd5: return (ones % 2) == 0;
      3'd6: return v[0];
      default: return !v[0];
    endcase
  endfunction

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare the default instance shortly after the edge.
  task automatic tick();
    logic [1:0] s, nclean;
    logic       nout, all_diff;
    @(posedge clk);
    if (rst) begin
      raw_hist.delete();
      s_hist.delete();
      m_clean = '0; m_out = 1'b0; m_chg = 1'b0; m_cnt = 0;
    end else begin
      // Debouncer sees the raw level from two edges ago.
      s = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 2'b00;
      raw_hist.push_back(raw);
      if (raw_hist.size() > 2) void'(raw_hist.pop_front());
      s_hist.push_back(s);
      if (s_hist.size() > D) void'(s_hist.pop_front());
      nclean = m_clean;
      if (s_hist.size() == D) begin
        for (int i = 0; i < N; i++) begin
          all_diff = 1'b1;
          for (int k = 0; k < D; k++)
            if (s_hist[k][i] == m_clean[i]) all_diff = 1'b0;
          if (all_diff) nclean[i] = ~m_clean[i];
        end
      end
      nout  = gate_ref(mode, m_clean);
      m_chg = (nout != m_out);
`ifdef TOGGLE_COUNT_EN
      if (m_chg && m_cnt < CMAX) m_cnt++;
`endif
      m_out   = nout;
      m_clean = nclean;
    end
    #1;
    check_eq("in_clean", 32'(clean), 32'(m_clean));
    check_eq("out_0", 32'(out0), 32'(m_out));
    check_eq("out_changed", 32'(chg), 32'(m_chg));
    check_eq("toggle_cnt", 32'(tcnt), 32'(m_cnt));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n, prev_cnt, exp2;
    logic seen;

    rst = 1'b1; rst2 = 1'b1; raw = 2'b11; mode = 3'd0;
    raw2 = 4'h0; mode2 = 3'd6;
    m_clean = '0; m_out = 1'b0; m_chg = 1'b0; m_cnt = 0;

    // Reset held with inputs active
    ticks(3);

    // Release: AND of 11 must appear exactly 7 edges later
    rst = 1'b0;
    n = 0;
    while (out0 !== 1'b1 && n < 20) begin tick(); n++; end
    check_eq("reset_latency", n, 7);

    // Truth table sweep
    for (int m = 0; m < 8; m++) begin
      for (int v = 0; v < 4; v++) begin
        mode = 3'(m);
        raw  = 2'(v);
        ticks(10);
        check_eq($sformatf("tt_m%0d_v%0d", m, v), 32'(out0), 32'(gate_ref(3'(m), 2'(v))));
      end
    end

    // Glitch rejection
    mode = 3'd1; raw = 2'b00; ticks(10);
    raw = 2'b01; ticks(3);
    raw = 2'b00;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (clean[0]) seen = 1'b1; end
    check_eq("glitch3_clean", 32'(seen), 0);
    check_eq("glitch3_out", 32'(out0), 0);
    raw = 2'b01; ticks(4);
    raw = 2'b00;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (clean[0]) seen = 1'b1; end
    check_eq("pulse4_clean", 32'(seen), 1);

    // Mode switch AND -> NAND on settled 11
    raw = 2'b11; mode = 3'd0; ticks(10);
    prev_cnt = int'(tcnt);
    mode = 3'd3; tick();
    check_eq("modesw_out", 32'(out0), 0);
    check_eq("modesw_chg", 32'(chg), 1);
`ifdef TOGGLE_COUNT_EN
    check_eq("modesw_cnt", 32'(tcnt), 32'(prev_cnt + 1));
`else
    check_eq("modesw_cnt", 32'(tcnt), 0);
`endif
    tick();
    check_eq("modesw_chg_drop", 32'(chg), 0);

    // Saturation on the 2-bit counter instance
    rst2 = 1'b0; ticks(14);
    for (int i = 0; i < 6; i++) begin
      mode2 = (i % 2 == 0) ? 3'd7 : 3'd6;
      tick();
      check_eq("sat_out", 32'(out2), (i % 2 == 0) ? 1 : 0);
`ifdef TOGGLE_COUNT_EN
      exp2 = (i + 1 < 3) ? i + 1 : 3;
`else
      exp2 = 0;
`endif
      check_eq($sformatf("sat_cnt%0d", i), 32'(tcnt2), 32'(exp2));
    end

    // Mid-debounce reset discards the partial count
    rst2 = 1'b1; tick();
    rst2 = 1'b0; mode2 = 3'd1; raw2 = 4'h0; ticks(3);
    raw2 = 4'b0100; ticks(7);
    check_eq("middeb_pending", 32'(clean2), 0);
    rst2 = 1'b1; tick();
    check_eq("middeb_rst_clean", 32'(clean2), 0);
    check_eq("middeb_rst_out", 32'(out2), 0);
    rst2 = 1'b0;
    n = 0;
    while (out2 !== 1'b1 && n < 30) begin tick(); n++; end
    check_eq("middeb_latency", n, 11);

    // Randomised traffic on the default instance
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 5) == 0) raw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) mode = 3'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0;
    ticks(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
